// File: rtl/lsu.sv
// Load/store unit: accepts one request from ex, runs a single-outstanding word bus access,
// and aligns/extends load data for write-back. Bad width/alignment completes with err.
module lsu #(
  parameter int unsigned Xlen     = 32,
  parameter int unsigned RegAddrW = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [Xlen-1:0]     req_addr_i,
  input  logic [Xlen-1:0]     req_wdata_i,
  input  logic [RegAddrW-1:0] req_rd_i,
  output logic                pause_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [3:0]          mem_wstrb_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [Xlen-1:0]     mem_rdata_i,
  output logic                regs_write_en_o,
  output logic [RegAddrW-1:0] regs_write_addr_o,
  output logic [Xlen-1:0]     regs_write_data_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic                mem_req_q, mem_we_q, regs_write_en_q, done_q, err_q;
  logic [Xlen-1:0]     mem_addr_q, mem_wdata_q, regs_write_data_q;
  logic [3:0]          mem_wstrb_q;
  logic [RegAddrW-1:0] rd_q;

  logic                req_ok;
  logic [3:0]          wstrb_d;
  logic [Xlen-1:0]     wdata_d;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [Xlen-1:0]     ld_data;

  // Request legality and store lane placement, decoded straight from the ex inputs.
  always_comb begin
    req_ok  = 1'b0;
    wstrb_d = 4'b0000;
    wdata_d = req_wdata_i;
    case (req_funct3_i)
      3'b000: begin
        req_ok = 1'b1;
        if (req_we_i) begin
          wstrb_d = 4'b0001 << req_addr_i[1:0];
          wdata_d = {4{req_wdata_i[7:0]}};
        end
      end
      3'b001: begin
        req_ok = ~req_addr_i[0];
        if (req_we_i) begin
          wstrb_d = 4'b0011 << req_addr_i[1:0];
          wdata_d = {2{req_wdata_i[15:0]}};
        end
      end
      3'b010: begin
        req_ok = (req_addr_i[1:0] == 2'b00);
        if (req_we_i) wstrb_d = 4'b1111;
      end
      3'b100:  req_ok = ~req_we_i;
      3'b101:  req_ok = ~req_we_i & ~req_addr_i[0];
      default: req_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      funct3_q          <= 3'b000;
      off_q             <= 2'b00;
      rd_q              <= '0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wstrb_q       <= 4'b0000;
      mem_wdata_q       <= '0;
      regs_write_en_q   <= 1'b0;
      regs_write_data_q <= '0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      // Completion pulses last exactly the one DONE cycle.
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      regs_write_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            funct3_q <= req_funct3_i;
            off_q    <= req_addr_i[1:0];
            rd_q     <= req_rd_i;
            if (req_ok) begin
              state_q     <= StWait;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= {req_addr_i[Xlen-1:2], 2'b00};
              mem_wstrb_q <= wstrb_d;
              mem_wdata_q <= wdata_d;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        StWait: begin
          if (mem_ready_i) begin
            state_q         <= StDone;
            mem_req_q       <= 1'b0;
            done_q          <= 1'b1;
            regs_write_en_q <= ~mem_we_q & (rd_q != '0);
            if (!mem_we_q) regs_write_data_q <= ld_data;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pause_o           = ((state_q == StIdle) & req_valid_i) | (state_q == StWait);
  assign mem_req_o         = mem_req_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wstrb_o       = mem_wstrb_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign regs_write_en_o   = regs_write_en_q;
  assign regs_write_addr_o = rd_q;
  assign regs_write_data_o = regs_write_data_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule
